// File: rtl/pad_debounce_sync_if.sv
// Pad conditioner bus: raw pad inputs in, debounced levels, edge pulses,
// stretched SoC reset and per-channel FSM debug state out.
//
// Handshake note: there is no valid/ready flow control on this bus. pad_i is
// sampled every clk edge; every output is a registered level that is valid on
// every cycle after the first clk edge with rst high.
interface pad_debounce_sync_if #(
    parameter int NCH = 3
);
    logic [NCH-1:0] pad_i;
    logic [NCH-1:0] level_o;
    logic [NCH-1:0] rise_o;
    logic [NCH-1:0] fall_o;
    logic           erst_n_o;
    logic [NCH-1:0] state_dbg_o;  // 1 = channel is in CHECK

    modport master (
        output pad_i,
        input  level_o, rise_o, fall_o, erst_n_o, state_dbg_o
    );

    modport slave (
        input  pad_i,
        output level_o, rise_o, fall_o, erst_n_o, state_dbg_o
    );
endinterface

// File: rtl/pad_debounce_sync.sv
// Board pad conditioner for the SoC: two-flop synchroniser, per-channel
// debounce FSM with registered rise/fall pulses, and a stretched active-low
// SoC reset derived from the masked debounced channels.
module pad_debounce_sync #(
    parameter int             NCH          = 3,
    parameter int             DEBOUNCE_CYC = 16000,
    parameter int             STRETCH_CYC  = 4096,
    parameter int             CNT_W        = 16,
    parameter logic [NCH-1:0] INIT_VAL     = 3'b111,
    parameter logic [NCH-1:0] RST_MASK     = 3'b011
) (
    input  logic                clk,
    input  logic                rst,
    pad_debounce_sync_if.slave  bus
);
    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] STR_LOAD = CNT_W'(STRETCH_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NCH-1:0] s1_q;
    logic [NCH-1:0] s2_q;
    logic [NCH-1:0] level_w;
    logic [NCH-1:0] rise_w;
    logic [NCH-1:0] fall_w;
    logic [NCH-1:0] check_w;

    // Two-flop synchroniser; the pads are asynchronous to clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= INIT_VAL;
            s2_q <= INIT_VAL;
        end else begin
            s1_q <= bus.pad_i;
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lvl_q, lvl_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        // Debounce state, counter, level and pulse registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                lvl_q   <= INIT_VAL[g];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lvl_q   <= lvl_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // Next state: the level flips only after DEBOUNCE_CYC consecutive
        // differing samples; any agreeing sample throws the run away.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            lvl_d   = lvl_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                ST_STABLE: begin
                    if (s2_q[g] != lvl_q) begin
                        state_d = ST_CHECK;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d   = '0;
                    end
                end
                ST_CHECK: begin
                    if (s2_q[g] == lvl_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= DEB_LAST) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                        lvl_d   = ~lvl_q;
                        rise_d  = ~lvl_q;
                        fall_d  = lvl_q;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign level_w[g] = lvl_q;
        assign rise_w[g]  = rise_q;
        assign fall_w[g]  = fall_q;
        assign check_w[g] = (state_q == ST_CHECK);
    end

    logic [CNT_W-1:0] str_q, str_d;
    logic             erst_n_q, erst_n_d;
    logic             any_rst;

    assign any_rst = |(~level_w & RST_MASK);

    // Stretch counter and SoC reset output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            str_q    <= STR_LOAD;
            erst_n_q <= 1'b0;
        end else begin
            str_q    <= str_d;
            erst_n_q <= erst_n_d;
        end
    end

    // Hold erst_n low while any masked channel is low, then for STRETCH_CYC
    // more cycles; a new assertion during the countdown reloads it.
    always_comb begin
        str_d    = str_q;
        erst_n_d = erst_n_q;
        if (any_rst) begin
            str_d    = STR_LOAD;
            erst_n_d = 1'b0;
        end else if (str_q != '0) begin
            str_d    = str_q - CNT_ONE;
            erst_n_d = 1'b0;
        end else begin
            erst_n_d = 1'b1;
        end
    end

    assign bus.level_o     = level_w;
    assign bus.rise_o      = rise_w;
    assign bus.fall_o      = fall_w;
    assign bus.erst_n_o    = erst_n_q;
    assign bus.state_dbg_o = check_w;
endmodule

// File: tb/tb_pad_debounce_sync.sv
// Bench for pad_debounce_sync with DEBOUNCE_CYC=4, STRETCH_CYC=8: directed
// scenarios followed by random pad activity, all outputs compared each cycle
// against a history-based reference model.
module tb_pad_debounce_sync;
    localparam int         NCH  = 3;
    localparam int         DEB  = 4;
    localparam int         STR  = 8;
    localparam logic [2:0] INIT = 3'b111;
    localparam logic [2:0] MASK = 3'b011;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] pad_r = INIT;
    always #5 clk = ~clk;

    pad_debounce_sync_if #(.NCH(NCH)) bif ();
    assign bif.pad_i = pad_r;

    pad_debounce_sync #(
        .NCH(NCH), .DEBOUNCE_CYC(DEB), .STRETCH_CYC(STR), .CNT_W(16),
        .INIT_VAL(INIT), .RST_MASK(MASK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    // ---------------- checker ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // pad_q holds the last two pad samples (what is still in flight through
    // the synchroniser); seen_q holds the last DEB values the debouncer saw.
    // A channel flips when all of the last DEB seen values disagree with it.
    // erst_n is high once the masked levels have been clear for more than
    // STR consecutive cycles.
    logic [2:0] pad_q[$];
    logic [2:0] seen_q[$];
    logic [2:0] m_level, m_rise, m_fall;
    logic       m_erst;
    int         quiet;

    task automatic model_edge(input logic r, input logic [2:0] p);
        logic [2:0] seen;
        logic [2:0] old_lvl;
        logic       all_diff;
        if (r) begin
            pad_q   = {INIT, INIT};
            seen_q  = {};
            m_level = INIT;
            m_rise  = '0;
            m_fall  = '0;
            quiet   = 0;
            m_erst  = 1'b0;
        end else begin
            old_lvl = m_level;
            seen = pad_q[pad_q.size() - 2];
            pad_q.push_back(p);
            while (pad_q.size() > 2) void'(pad_q.pop_front());
            seen_q.push_back(seen);
            while (seen_q.size() > DEB) void'(seen_q.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NCH; c++) begin
                all_diff = (seen_q.size() == DEB);
                foreach (seen_q[k]) if (seen_q[k][c] == old_lvl[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[c] = ~old_lvl[c];
                    m_rise[c]  = ~old_lvl[c];
                    m_fall[c]  = old_lvl[c];
                end
            end
            if ((~old_lvl & MASK) != 3'b000) quiet = 0;
            else if (quiet < 1000) quiet++;
            m_erst = (quiet > STR);
        end
    endtask

    // ---------------- driver / monitor ----------------
    int cyc = 0;
    int fall_cnt[NCH];
    int rise_cnt[NCH];
    int last_fall[NCH];
    int last_rise[NCH];
    int erst_rise_cyc = -1;
    int erst_fall_cyc = -1;
    logic prev_erst = 1'b0;

    task automatic clear_marks();
        for (int c = 0; c < NCH; c++) begin
            fall_cnt[c] = 0; rise_cnt[c] = 0; last_fall[c] = -1; last_rise[c] = -1;
        end
        erst_rise_cyc = -1;
        erst_fall_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge(rst, pad_r);
        #1;
        check_val("level_o",  32'(bif.level_o),  32'(m_level));
        check_val("rise_o",   32'(bif.rise_o),   32'(m_rise));
        check_val("fall_o",   32'(bif.fall_o),   32'(m_fall));
        check_val("erst_n_o", 32'(bif.erst_n_o), 32'(m_erst));
        for (int c = 0; c < NCH; c++) begin
            if (bif.fall_o[c]) begin fall_cnt[c]++; last_fall[c] = cyc; end
            if (bif.rise_o[c]) begin rise_cnt[c]++; last_rise[c] = cyc; end
        end
        if (bif.erst_n_o && !prev_erst) erst_rise_cyc = cyc;
        if (!bif.erst_n_o && prev_erst) erst_fall_cyc = cyc;
        prev_erst = bif.erst_n_o;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_pad(input int ch, input int n);
        pad_r[ch] = 1'b0;
        ticks(n);
        pad_r[ch] = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int r_edge;
    int step;

    initial begin
        clear_marks();
        // 1: reset release with idle pads
        rst = 1'b1; pad_r = INIT;
        ticks(2);
        check_val("rst_state_dbg", 32'(bif.state_dbg_o), 32'd0);
        r_edge = cyc;
        rst = 1'b0;
        ticks(12);
        check_val("t1_erst_rise", 32'(erst_rise_cyc), 32'(r_edge + 9));
        check_val("t1_no_fall", 32'(fall_cnt[0] + fall_cnt[1] + fall_cnt[2]), 32'd0);
        check_val("t1_no_rise", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2]), 32'd0);

        // 2: wakeup channel step low
        clear_marks();
        step = cyc;
        pad_r[2] = 1'b0;
        ticks(10);
        check_val("t2_fall_time", 32'(last_fall[2]), 32'(step + 6));
        check_val("t2_fall_once", 32'(fall_cnt[2]), 32'd1);
        check_val("t2_erst_quiet", 32'(erst_fall_cyc), 32'hffff_ffff);
        pad_r[2] = 1'b1;
        ticks(8);

        // 3: glitch rejection, then minimum accepted press
        clear_marks();
        pulse_pad(0, 3);
        ticks(8);
        check_val("t3_glitch_fall", 32'(fall_cnt[0]), 32'd0);
        pulse_pad(0, 4);
        ticks(20);
        check_val("t3_press_fall", 32'(fall_cnt[0]), 32'd1);

        // 4: masked channel press and stretch
        clear_marks();
        pulse_pad(1, 10);
        ticks(20);
        check_val("t4_erst_low", 32'(erst_fall_cyc), 32'(last_fall[1] + 1));
        check_val("t4_erst_high", 32'(erst_rise_cyc), 32'(last_rise[1] + 9));

        // 5: second press during the stretch window reloads the counter
        clear_marks();
        pulse_pad(1, 6);
        ticks(8);
        pulse_pad(0, 5);
        ticks(25);
        check_val("t5_erst_high", 32'(erst_rise_cyc), 32'(last_rise[0] + 9));
        check_val("t5_one_rise", 32'(erst_rise_cyc > last_rise[1] + 9), 32'd1);

        // 6: reset mid-CHECK discards progress
        clear_marks();
        pad_r[2] = 1'b0;
        ticks(3);
        check_val("t6_in_check", 32'(bif.state_dbg_o[2]), 32'd1);
        rst = 1'b1;
        ticks(1);
        r_edge = cyc;
        rst = 1'b0;
        ticks(10);
        check_val("t6_fall_time", 32'(last_fall[2]), 32'(r_edge + 6));
        check_val("t6_fall_once", 32'(fall_cnt[2]), 32'd1);
        pad_r[2] = 1'b1;
        ticks(20);

        // random pad activity with occasional resets
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 5) == 0) pad_r[c] = ~pad_r[c];
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        ticks(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
